// File: rtl/scalar_wb_pkg.sv
// Shared types for the scalar writeback path: register index, data word and
// the request payload carried through the vector-result FIFO.
package scalar_wb_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_BITS = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_BITS-1:0] data_t;

  typedef struct packed {
    reg_idx_t rd;
    data_t    data;
  } wb_req_t;

  localparam reg_idx_t X0_IDX = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; pointers wrap naturally
// because the depth is a power of two.
module wb_fifo
  import scalar_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  wb_req_t                din,
  output wb_req_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy state; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/scalar_wb_unit.sv
// Scalar register-file writeback arbiter: merges ALU results with buffered
// vector-unit scalar results and tracks registers reserved by vector ops.
module scalar_wb_unit
  import scalar_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [$clog2(NUM_REGS)-1:0]   alu_rd,
  input  logic [DATA_W-1:0]             alu_data,
  output logic                          alu_stall,
  input  logic                          vec_valid,
  output logic                          vec_ready,
  input  logic [$clog2(NUM_REGS)-1:0]   vec_rd,
  input  logic [DATA_W-1:0]             vec_data,
  input  logic                          mark_valid,
  input  logic [$clog2(NUM_REGS)-1:0]   mark_rd,
  output logic [NUM_REGS-1:0]           busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          reg_write,
  output logic [$clog2(NUM_REGS)-1:0]   wr_reg,
  output logic [DATA_W-1:0]             write_data_sca
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  wb_req_t             push_req;
  wb_req_t             head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                sel_valid;
  reg_idx_t            sel_rd;
  data_t               sel_data;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_nxt;

  assign vec_ready     = !rst && !fifo_full;
  assign push          = vec_valid && vec_ready;
  assign push_req.rd   = reg_idx_t'(vec_rd);
  assign push_req.data = data_t'(vec_data);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_req),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A full FIFO preempts the ALU so vector results cannot starve behind it.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = X0_IDX;
    sel_data  = '0;
    pop       = 1'b0;
    alu_stall = 1'b0;
    if (!rst) begin
      if (fifo_full && !fifo_empty) begin
        pop       = 1'b1;
        alu_stall = alu_valid;
        sel_valid = (head.rd != X0_IDX);
        sel_rd    = head.rd;
        sel_data  = head.data;
      end else if (alu_valid) begin
        sel_valid = (reg_idx_t'(alu_rd) != X0_IDX);
        sel_rd    = reg_idx_t'(alu_rd);
        sel_data  = data_t'(alu_data);
      end else if (!fifo_empty) begin
        pop       = 1'b1;
        sel_valid = (head.rd != X0_IDX);
        sel_rd    = head.rd;
        sel_data  = head.data;
      end
    end
  end

  // Reservation wins over a same-cycle release of the same register.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (mark_valid) set_mask[mark_rd] = 1'b1;
    if (pop && head.rd != X0_IDX) clr_mask[head.rd] = 1'b1;
    busy_nxt = (busy & ~clr_mask) | set_mask;
    busy_nxt[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write      <= 1'b0;
      wr_reg         <= '0;
      write_data_sca <= '0;
      busy           <= '0;
    end else begin
      reg_write <= sel_valid;
      if (sel_valid) begin
        wr_reg         <= IDX_W'(sel_rd);
        write_data_sca <= DATA_W'(sel_data);
      end
      busy <= busy_nxt;
    end
  end

  // Issue must not reserve a register that is still pending (unless it retires now).
  assert property (@(posedge clk) disable iff (rst)
    !(mark_valid && (reg_idx_t'(mark_rd) != X0_IDX) && busy[mark_rd] && !clr_mask[mark_rd]));

endmodule

// File: tb/tb_scalar_wb_unit.sv
// Bench for scalar_wb_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_scalar_wb_unit;
  import scalar_wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        vec_valid;
  logic        vec_ready;
  logic [4:0]  vec_rd;
  logic [31:0] vec_data;
  logic        mark_valid;
  logic [4:0]  mark_rd;
  logic [31:0] busy;
  logic [2:0]  fifo_count;
  logic        reg_write;
  logic [4:0]  wr_reg;
  logic [31:0] write_data_sca;

  int errors = 0;
  int checks = 0;

  scalar_wb_unit dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_rd(vec_rd), .vec_data(vec_data),
    .mark_valid(mark_valid), .mark_rd(mark_rd), .busy(busy), .fifo_count(fifo_count),
    .reg_write(reg_write), .wr_reg(wr_reg), .write_data_sca(write_data_sca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: the FIFO as a queue, reservations as a bit set, last write.
  wb_req_t     mq[$];
  logic [31:0] mbusy = '0;
  logic        m_rw  = 1'b0;
  logic [4:0]  m_wr  = '0;
  logic [31:0] m_wd  = '0;

  // Compare process: outputs are stable at the falling edge; then advance the model.
  always @(negedge clk) begin
    bit      full;
    bit      do_pop;
    bit      wr;
    wb_req_t h;
    logic [4:0]  wr_i;
    logic [31:0] wd_i;
    if (rst) begin
      mq.delete();
      mbusy = '0; m_rw = 1'b0; m_wr = '0; m_wd = '0;
    end
    full = (mq.size() == 4);
    check("m_reg_write", reg_write, m_rw);
    check("m_wr_reg", wr_reg, m_wr);
    check("m_wdata", write_data_sca, m_wd);
    check("m_busy", busy, mbusy);
    check("m_count", fifo_count, mq.size());
    check("m_vec_ready", vec_ready, !rst && !full);
    check("m_alu_stall", alu_stall, !rst && full && alu_valid);
    if (!rst) begin
      do_pop = 1'b0; wr = 1'b0; wr_i = '0; wd_i = '0;
      if (full) do_pop = 1'b1;
      else if (alu_valid) begin
        wr = (alu_rd != 0); wr_i = alu_rd; wd_i = alu_data;
      end else if (mq.size() != 0) do_pop = 1'b1;
      if (do_pop) begin
        h = mq.pop_front();
        wr = (h.rd != 0); wr_i = h.rd; wd_i = h.data;
        if (h.rd != 0) mbusy[h.rd] = 1'b0;
      end
      if (vec_valid && !full) mq.push_back('{rd: vec_rd, data: vec_data});
      if (mark_valid) mbusy[mark_rd] = 1'b1;
      mbusy[0] = 1'b0;
      m_rw = wr;
      if (wr) begin m_wr = wr_i; m_wd = wd_i; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; vec_valid = 0; mark_valid = 0;
  endtask

  initial begin
    logic [4:0] rsv [3];
    rsv[0] = 5'd8; rsv[1] = 5'd10; rsv[2] = 5'd11;
    rst = 1'b1;
    idle();
    alu_rd = '0; alu_data = '0; vec_rd = '0; vec_data = '0; mark_rd = '0;
    alu_valid = 1'b1;
    #2;
    check("rst_reg_write", reg_write, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_vec_ready", vec_ready, 0);
    check("rst_alu_stall", alu_stall, 0);
    alu_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    check("alu_rw", reg_write, 1);
    check("alu_wr", wr_reg, 5);
    check("alu_wd", write_data_sca, 32'hDEADBEEF);
    tick();
    check("alu_rw_drop", reg_write, 0);
    check("alu_wr_hold", wr_reg, 5);

    // Priority: FIFO pops only when the ALU is idle
    mark_valid = 1; mark_rd = 7;
    tick();
    mark_valid = 0;
    check("prio_busy_set", busy, 32'h80);
    vec_valid = 1; vec_rd = 7; vec_data = 32'h11;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    tick();
    vec_valid = 0;
    check("prio_count1", fifo_count, 1);
    tick();
    check("prio_count_held", fifo_count, 1);
    check("prio_busy_held", busy, 32'h80);
    check("prio_alu_wr", wr_reg, 3);
    alu_valid = 0;
    tick();
    check("prio_pop_rw", reg_write, 1);
    check("prio_pop_wr", wr_reg, 7);
    check("prio_pop_wd", write_data_sca, 32'h11);
    check("prio_busy_clr", busy, 0);

    // Starvation guard
    alu_valid = 1; alu_rd = 1; vec_valid = 1;
    for (int i = 0; i < 4; i++) begin
      vec_rd = 5'(10 + i); vec_data = 32'hA0 + 32'(i); alu_data = 32'(i);
      tick();
    end
    vec_valid = 0;
    check("starv_count4", fifo_count, 4);
    check("starv_not_ready", vec_ready, 0);
    check("starv_stall", alu_stall, 1);
    tick();
    check("starv_rw", reg_write, 1);
    check("starv_wr", wr_reg, 10);
    check("starv_wd", write_data_sca, 32'hA0);
    check("starv_count3", fifo_count, 3);
    check("starv_ready", vec_ready, 1);
    check("starv_no_stall", alu_stall, 0);
    alu_valid = 0;
    repeat (3) tick();
    check("drain_count", fifo_count, 0);
    check("drain_wr", wr_reg, 13);
    check("drain_wd", write_data_sca, 32'hA3);

    // x0 handling
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    tick();
    alu_valid = 0;
    check("x0_alu_rw", reg_write, 0);
    check("x0_alu_wr_hold", wr_reg, 13);
    vec_valid = 1; vec_rd = 0; vec_data = 32'h66;
    mark_valid = 1; mark_rd = 0;
    tick();
    idle();
    check("x0_push_rw", reg_write, 0);
    check("x0_busy", busy, 0);
    check("x0_count", fifo_count, 1);
    tick();
    check("x0_pop_rw", reg_write, 0);
    check("x0_pop_count", fifo_count, 0);
    check("x0_wd_hold", write_data_sca, 32'hA3);

    // Set/clear collision on x9
    mark_valid = 1; mark_rd = 9;
    tick();
    mark_valid = 0;
    vec_valid = 1; vec_rd = 9; vec_data = 32'h99;
    tick();
    vec_valid = 0;
    check("coll_count", fifo_count, 1);
    mark_valid = 1; mark_rd = 9;
    tick();
    mark_valid = 0;
    check("coll_rw", reg_write, 1);
    check("coll_wr", wr_reg, 9);
    check("coll_wd", write_data_sca, 32'h99);
    check("coll_busy", busy, 32'h200);

    // Async reset with 3 entries and busy = 0xF00
    for (int i = 0; i < 3; i++) begin
      mark_valid = 1; mark_rd = rsv[i];
      vec_valid = 1; vec_rd = 5'(20 + i); vec_data = 32'hC0 + 32'(i);
      alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
      tick();
    end
    idle();
    check("pre_rst_busy", busy, 32'h0F00);
    check("pre_rst_count", fifo_count, 3);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_count", fifo_count, 0);
    check("arst_rw", reg_write, 0);
    check("arst_ready", vec_ready, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      check("post_rst_rw", reg_write, 0);
      check("post_rst_count", fifo_count, 0);
    end

    // Randomized traffic; reservations avoid registers the model says are pending
    for (int i = 0; i < 3000; i++) begin
      alu_valid  = ($urandom_range(0, 99) < 60);
      alu_rd     = 5'($urandom_range(0, 31));
      alu_data   = $urandom;
      vec_valid  = ($urandom_range(0, 99) < 55);
      vec_rd     = 5'($urandom_range(0, 31));
      vec_data   = $urandom;
      mark_rd    = 5'($urandom_range(0, 31));
      mark_valid = ($urandom_range(0, 3) == 0) && (mark_rd == 0 || !mbusy[mark_rd]);
      if (i == 1500) begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
      end
      tick();
    end
    idle();
    repeat (8) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scalar_wb_unit.md
Name: scalar_wb_unit

Overview:
- Scalar writeback initiator.
- Drives the single write port (reg_write / wr_reg / write_data_sca) of the scalar register file.
- Merges two producers:
  - the single-cycle scalar ALU;
  - long-latency scalar results from the vector unit (vmv.x.s, reductions, vsetvl), buffered in a small FIFO.
- Keeps a 32-bit busy scoreboard for registers reserved by in-flight vector ops, so issue can stall on RAW hazards.

Parameters:
- DATA_W, 32, register data width
- NUM_REGS, 32, architectural scalar registers; index width $clog2(NUM_REGS)
- FIFO_DEPTH, 4, vector-result FIFO entries, power of two, >=2

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU writeback request this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  ALU request not taken this cycle; upstream holds request
- vec_valid  in  1  vector-unit scalar result valid
- vec_ready  out  1  FIFO can accept (valid&ready = push)
- vec_rd  in  5  vector-result destination
- vec_data  in  32  vector-result data
- mark_valid  in  1  issue reserves a destination for a vector op
- mark_rd  in  5  register to reserve
- busy  out  32  scoreboard, bit i = register i pending
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- reg_write  out  1  regfile write enable (registered)
- wr_reg  out  5  regfile write index (registered)
- write_data_sca  out  32  regfile write data (registered)

Behaviour:
- Reset (rst=1, async), all forced immediately:
  - reg_write=0, wr_reg=0, write_data_sca=0, busy=0, fifo empty, fifo_count=0.
  - vec_ready=0 and alu_stall=0 while rst is high.
- Output registers: reg_write, wr_reg and write_data_sca are flops.
  - A request selected in cycle N appears on the regfile port in cycle N+1 and holds for exactly one cycle.
  - With nothing selected, reg_write=0; wr_reg and write_data_sca keep their last values.
- Selection each cycle (fixed priority with starvation guard):
  1. FIFO full (count==FIFO_DEPTH) and not empty: pop the FIFO head. alu_stall = alu_valid (combinational); the ALU request is not written.
  2. Else if alu_valid: write the ALU result; alu_stall=0.
  3. Else if the FIFO is non-empty: pop the head.
  4. Else idle.
- x0 handling:
  - alu_rd==0 is consumed with no write.
  - A FIFO entry with rd==0 is popped with reg_write=0 for that slot.
  - busy[0] is hard-wired 0.
- FIFO:
  - vec_ready = !full (combinational from count).
  - Push and pop in the same cycle leaves count unchanged, with data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - No push is possible when full; a pop from full re-enables vec_ready the next cycle.
- Scoreboard:
  - mark_valid sets busy[mark_rd] at the clock edge.
  - A FIFO pop with rd!=0 clears busy[rd] at the same edge as the write is launched. busy drops in the cycle reg_write=1 is presented.
  - Simultaneous set and clear of the same index: set wins (new reservation).
  - Mark of an already-busy register leaves it set. This is an issue-protocol violation; flag it with an assertion.
  - ALU writes never modify busy.
- Reset mid-operation: FIFO contents and reservations are discarded; no partial write is issued after rst falls.
- Width rules: data passes through unchanged; no sign or zero manipulation.

Decomposition:
- Shared package scalar_wb_pkg:
  - reg_idx_t (logic [4:0]), data_t (logic [31:0]);
  - wb_req_t struct {reg_idx_t rd; data_t data;};
  - localparam X0_IDX = 0.
- One sub-module: wb_fifo.
  - Synchronous FIFO of wb_req_t: depth FIFO_DEPTH, push/pop/full/empty/count.
  - Async active-high reset.
- Arbitration and scoreboard stay in scalar_wb_unit.

Test Plan:
- ALU only: alu_valid with rd=5, data=0xDEADBEEF at cycle 3 -> cycle 4: reg_write=1, wr_reg=5, write_data_sca=0xDEADBEEF; cycle 5: reg_write=0.
- Priority: mark rd=7 at cycle 1; vec push rd=7, data=0x11; ALU idle, then ALU valid every cycle:
  - FIFO pops only in idle ALU cycles;
  - busy[7] goes 1 -> 0 on the edge where wr_reg=7 and data 0x11 are presented.
- Starvation guard: ALU valid continuously, 4 vec pushes -> FIFO reaches 4 and vec_ready=0:
  - next cycle alu_stall=1 and the FIFO head is written;
  - count=3 and vec_ready=1 the cycle after.
- x0: alu_rd=0, vec_rd=0 entries -> no reg_write pulses; busy stays 0 after mark_rd=0.
- Set/clear collision: pending rd=9 popping while mark_rd=9 in the same cycle -> write to x9 issued, busy[9] remains 1.
- Async reset with 3 FIFO entries and busy=0x0000_0F00 -> immediately busy=0, fifo_count=0, reg_write=0, vec_ready=0; no writes after release.
